// File: rtl/text_label_sequencer.sv
// rtl/text_label_sequencer.sv - frame-synchronous position/enable/blink sequencer and overlay merge for up to four text labels
// Optional blink support is built when TEXT_LABEL_BLINK_EN is defined.
module text_label_sequencer #(
    parameter int NUM_LABELS   = 4,
    parameter int BLINK_FRAMES = 30,
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int LABEL_W      = 64,
    parameter int LABEL_H      = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     frame_tick,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [1:0]               cfg_idx,
    input  logic [9:0]               cfg_x,
    input  logic [9:0]               cfg_y,
    input  logic                     cfg_en,
    input  logic                     cfg_blink,
    input  logic [NUM_LABELS-1:0]    label_hit,
    output logic [10*NUM_LABELS-1:0] top_left_x,
    output logic [10*NUM_LABELS-1:0] top_left_y,
    output logic                     pix_on,
    output logic [1:0]               pix_sel
);

    localparam logic [9:0] X_MAX = 10'(H_RES - LABEL_W);
    localparam logic [9:0] Y_MAX = 10'(V_RES - LABEL_H);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   commit;

    // Shadow slot holding one accepted, not-yet-committed request
    logic [1:0] sh_idx;
    logic [9:0] sh_x;
    logic [9:0] sh_y;
    logic       sh_en;

    // Live per-label registers seen by the renderers
    logic [9:0]            x_q [NUM_LABELS];
    logic [9:0]            y_q [NUM_LABELS];
    logic [NUM_LABELS-1:0] en_q;
    logic [NUM_LABELS-1:0] visible;
    logic [NUM_LABELS-1:0] eligible;
    logic [1:0]            win_sel;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM next state, handshake and commit strobe
    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    accept    = 1'b1;
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (frame_tick) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture request into the shadow slot, clamping so the label stays on screen
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_idx <= '0;
            sh_x   <= '0;
            sh_y   <= '0;
            sh_en  <= 1'b0;
        end else if (accept) begin
            sh_idx <= cfg_idx;
            sh_x   <= (cfg_x > X_MAX) ? X_MAX : cfg_x;
            sh_y   <= (cfg_y > Y_MAX) ? Y_MAX : cfg_y;
            sh_en  <= cfg_en;
        end
    end

    // Commit shadow slot into the addressed label; out-of-range indices match nothing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LABELS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            en_q <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_LABELS; i++) begin
                if (int'(sh_idx) == i) begin
                    x_q[i]  <= sh_x;
                    y_q[i]  <= sh_y;
                    en_q[i] <= sh_en;
                end
            end
        end
    end

`ifdef TEXT_LABEL_BLINK_EN
    logic                  sh_blink;
    logic [7:0]            blink_cnt;
    logic                  blink_phase;
    logic [NUM_LABELS-1:0] blink_q;

    // Shadow copy of the blink request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    sh_blink <= 1'b0;
        else if (accept) sh_blink <= cfg_blink;
    end

    // Per-label blink flags, committed together with position and enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_q <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_LABELS; i++) begin
                if (int'(sh_idx) == i) blink_q[i] <= sh_blink;
            end
        end
    end

    // Frame counter; phase flips every BLINK_FRAMES frames
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

    // Blinking labels are hidden during the odd phase
    always_comb begin
        visible = ~(blink_q & {NUM_LABELS{blink_phase}});
    end
`else
    logic unused_blink;
    assign unused_blink = cfg_blink;

    // Without blink support every enabled label is always visible
    always_comb begin
        visible = '1;
    end
`endif

    // Pack live positions onto the renderer buses
    always_comb begin
        top_left_x = '0;
        top_left_y = '0;
        for (int i = 0; i < NUM_LABELS; i++) begin
            top_left_x[10*i +: 10] = x_q[i];
            top_left_y[10*i +: 10] = y_q[i];
        end
    end

    // Lowest eligible label index wins the pixel
    always_comb begin
        eligible = label_hit & en_q & visible;
        win_sel  = '0;
        for (int i = NUM_LABELS - 1; i >= 0; i--) begin
            if (eligible[i]) win_sel = 2'(i);
        end
    end

    // Registered merged overlay output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_on  <= 1'b0;
            pix_sel <= '0;
        end else begin
            pix_on  <= |eligible;
            pix_sel <= win_sel;
        end
    end

endmodule
